// File: rtl/comparator_stimulus_checker.sv
// Self-test sequencer for the 3-bit word comparator: sweeps all 64 (S, I) pairs,
// checks the 12 result lines against the ideal response and records failures.
module comparator_stimulus_checker #(
    parameter int unsigned PACE_CYCLES = 4,
    parameter bit          ACTIVE_LOW  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] y_in,
    output logic        out_a,
    output logic        out_b,
    output logic        out_c,
    output logic        out_d,
    output logic        out_e,
    output logic        out_f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [6:0]  err_count,
    output logic        fail_valid,
    output logic [5:0]  fail_idx,
    output logic [11:0] fail_mask
);

    localparam int unsigned PW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [PW-1:0] PACE_LAST = PW'(PACE_CYCLES - 1);
    localparam logic [5:0] DRIVE_XOR = ACTIVE_LOW ? 6'h3F : 6'h00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [5:0]     r_idx;
    logic [5:0]     w_idx_nxt;
    logic [PW-1:0]  r_pace;
    logic [PW-1:0]  w_pace_nxt;
    logic [6:0]     r_err;
    logic [6:0]     w_err_nxt;
    logic           r_fail_valid;
    logic           w_fail_valid_nxt;
    logic [5:0]     r_fail_idx;
    logic [5:0]     w_fail_idx_nxt;
    logic [11:0]    r_fail_mask;
    logic [11:0]    w_fail_mask_nxt;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic [5:0]     r_drive;
    logic [11:0]    w_expected;
    logic [11:0]    w_diff;
    logic           w_mismatch;

    // Ideal comparator response for vector {S, I}, unsigned
    function automatic logic [11:0] f_expected(input logic [5:0] vec);
        logic [2:0]  s;
        logic [2:0]  i;
        logic [11:0] y;
        s = vec[5:3];
        i = vec[2:0];
        y = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            y[k]     = ~s[k] & i[k];
            y[3 + k] = ~(s[k] ^ i[k]);
            y[6 + k] = s[k] & ~i[k];
        end
        y[9]  = (s < i);
        y[10] = (s == i);
        y[11] = (s > i);
        return y;
    endfunction

    assign w_expected = f_expected(r_idx);
    assign w_diff     = y_in ^ w_expected;
    assign w_mismatch = |w_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_pace_nxt       = r_pace;
        w_err_nxt        = r_err;
        w_fail_valid_nxt = r_fail_valid;
        w_fail_idx_nxt   = r_fail_idx;
        w_fail_mask_nxt  = r_fail_mask;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt      = S_APPLY;
                    w_idx_nxt        = '0;
                    w_pace_nxt       = '0;
                    w_err_nxt        = '0;
                    w_fail_valid_nxt = 1'b0;
                    w_fail_idx_nxt   = '0;
                    w_fail_mask_nxt  = '0;
                end
            end
            S_APPLY: begin
                if (r_pace == PACE_LAST) begin
                    w_state_nxt = S_CHECK;
                    w_pace_nxt  = '0;
                end else begin
                    w_pace_nxt = r_pace + 1'b1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err + 7'd1;
                    if (!r_fail_valid) begin
                        w_fail_valid_nxt = 1'b1;
                        w_fail_idx_nxt   = r_idx;
                        w_fail_mask_nxt  = w_diff;
                    end
                end
                if (r_idx == 6'd63) begin
                    w_state_nxt = S_DONE;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = S_APPLY;
                    w_idx_nxt   = r_idx + 6'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status and drive flops load from next-state values so they change on the same edge as the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_pace       <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_fail_mask  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_drive      <= DRIVE_XOR;
        end else begin
            r_idx        <= w_idx_nxt;
            r_pace       <= w_pace_nxt;
            r_err        <= w_err_nxt;
            r_fail_valid <= w_fail_valid_nxt;
            r_fail_idx   <= w_fail_idx_nxt;
            r_fail_mask  <= w_fail_mask_nxt;
            r_busy       <= (w_state_nxt == S_APPLY) || (w_state_nxt == S_CHECK);
            r_done       <= (w_state_nxt == S_DONE);
            r_pass       <= (w_state_nxt == S_DONE) && (w_err_nxt == 7'd0);
            r_drive      <= w_idx_nxt ^ DRIVE_XOR;
        end
    end

    assign out_a      = r_drive[5];
    assign out_b      = r_drive[4];
    assign out_c      = r_drive[3];
    assign out_d      = r_drive[2];
    assign out_e      = r_drive[1];
    assign out_f      = r_drive[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_idx   = r_fail_idx;
    assign fail_mask  = r_fail_mask;

endmodule

// File: tb/tb_comparator_stimulus_checker.sv
// Bench for comparator_stimulus_checker: a board-level comparator model feeds y_in,
// and a sweep-level model predicts every output each cycle for both pin polarities.
module tb_comparator_stimulus_checker;

    localparam int PACE  = 4;
    localparam int PER   = PACE + 1;
    localparam int SWEEP = 64 * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   fault = 0;

    always #5 clk = ~clk;

    logic [11:0] y0, y1;
    logic a0, b0, c0, d0, e0, f0, busy0, done0, pass0, fv0;
    logic a1, b1, c1, d1, e1, f1, busy1, done1, pass1, fv1;
    logic [6:0]  err0, err1;
    logic [5:0]  fidx0, fidx1;
    logic [11:0] fmask0, fmask1;

    comparator_stimulus_checker #(.PACE_CYCLES(PACE), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .y_in(y0),
        .out_a(a0), .out_b(b0), .out_c(c0), .out_d(d0), .out_e(e0), .out_f(f0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .fail_idx(fidx0), .fail_mask(fmask0)
    );

    comparator_stimulus_checker #(.PACE_CYCLES(PACE), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .start(start), .y_in(y1),
        .out_a(a1), .out_b(b1), .out_c(c1), .out_d(d1), .out_e(e1), .out_f(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_idx(fidx1), .fail_mask(fmask1)
    );

    function automatic logic [11:0] golden(input int s, input int i);
        logic [11:0] y;
        int sb, ib;
        y = '0;
        for (int k = 0; k < 3; k++) begin
            sb = (s >> k) & 1;
            ib = (i >> k) & 1;
            y[k]     = (sb < ib);
            y[3 + k] = (sb == ib);
            y[6 + k] = (sb > ib);
        end
        y[9]  = (s < i);
        y[10] = (s == i);
        y[11] = (s > i);
        return y;
    endfunction

    function automatic logic [11:0] with_fault(input logic [11:0] y, input int f);
        logic [11:0] r;
        r = y;
        if (f == 1) r[0] = 1'b1;
        if (f == 2) r[10] = 1'b0;
        return r;
    endfunction

    // Comparator board model: active-low instance sees its pins inverted back
    always_comb begin
        y0 = with_fault(golden(int'({a0, b0, c0}), int'({d0, e0, f0})), fault);
        y1 = with_fault(golden(int'(~{a1, b1, c1}) & 7, int'(~{d1, e1, f1}) & 7), fault);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit m_known = 0;
    bit m_active = 0;
    int m_n = 0;
    int m_fault_run = 0;

    always @(posedge clk) begin
        int e_idx, e_chk, e_err, e_fidx, e_fmask;
        bit e_busy, e_done, e_fv;
        logic [11:0] yg, yf;
        #1;
        if (rst) begin
            m_known = 1;
            m_active = 0;
            m_n = 0;
        end else if (start && (!m_active || m_n >= SWEEP)) begin
            m_active = 1;
            m_n = 0;
            m_fault_run = fault;
        end else if (m_active && m_n < SWEEP) begin
            m_n++;
        end

        if (m_known) begin
            e_idx = 0; e_chk = 0; e_busy = 0; e_done = 0;
            if (m_active && m_n < SWEEP) begin
                e_idx = m_n / PER;
                e_chk = m_n / PER;
                e_busy = 1;
            end else if (m_active) begin
                e_chk = 64;
                e_done = 1;
            end
            e_err = 0; e_fv = 0; e_fidx = 0; e_fmask = 0;
            for (int k = 0; k < e_chk; k++) begin
                yg = golden(k >> 3, k & 7);
                yf = with_fault(yg, m_fault_run);
                if (yf != yg) begin
                    e_err++;
                    if (!e_fv) begin
                        e_fv = 1;
                        e_fidx = k;
                        e_fmask = int'(yf ^ yg);
                    end
                end
            end
            chk("pins", int'({a0, b0, c0, d0, e0, f0}), e_idx);
            chk("pins_al", int'({a1, b1, c1, d1, e1, f1}), e_idx ^ 6'h3F);
            chk("busy", int'(busy0), int'(e_busy));
            chk("busy_al", int'(busy1), int'(e_busy));
            chk("done", int'(done0), int'(e_done));
            chk("done_al", int'(done1), int'(e_done));
            chk("pass", int'(pass0), int'(e_done && e_err == 0));
            chk("pass_al", int'(pass1), int'(e_done && e_err == 0));
            chk("err_count", int'(err0), e_err);
            chk("err_count_al", int'(err1), e_err);
            chk("fail_valid", int'(fv0), int'(e_fv));
            chk("fail_idx", int'(fidx0), e_fidx);
            chk("fail_mask", int'(fmask0), e_fmask);
            chk("fail_mask_al", int'(fmask1), e_fmask);
        end
    end

    // Start a sweep (optionally re-pulsing start mid-sweep) and return cycles from the start edge to done
    task automatic run_sweep(input int fsel, input bit mid_start, output int cyc);
        fault = fsel;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("lit_restart_err", int'(err0), 0);
        chk("lit_restart_fv", int'(fv0), 0);
        chk("lit_restart_mask", int'(fmask0), 0);
        chk("lit_restart_busy", int'(busy0), 1);
        chk("lit_restart_pins", int'({a0, b0, c0, d0, e0, f0}), 0);
        cyc = 0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = mid_start && (cyc == 100);
            if (cyc == 215) begin
                chk("lit_pins_2B", int'({a0, b0, c0, d0, e0, f0}), 6'h2B);
                chk("lit_pins_al_2B", int'({a1, b1, c1, d1, e1, f1}), 6'b010100);
            end
            if (done0) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("lit_reset_pins", int'({a0, b0, c0, d0, e0, f0}), 0);
        chk("lit_reset_pins_al", int'({a1, b1, c1, d1, e1, f1}), 6'h3F);
        chk("lit_reset_busy", int'(busy0), 0);
        chk("lit_reset_done", int'(done0), 0);

        run_sweep(0, 1'b1, cyc);
        chk("lit_done_latency", cyc, 320);
        chk("lit_clean_pass", int'(pass0), 1);
        chk("lit_clean_pass_al", int'(pass1), 1);
        chk("lit_clean_err", int'(err0), 0);
        chk("lit_clean_fv", int'(fv0), 0);

        run_sweep(1, 1'b0, cyc);
        chk("lit_s1_latency", cyc, 320);
        chk("lit_s1_err", int'(err0), 48);
        chk("lit_s1_fidx", int'(fidx0), 0);
        chk("lit_s1_mask", int'(fmask0), 12'h001);
        chk("lit_s1_fv", int'(fv0), 1);
        chk("lit_s1_pass", int'(pass0), 0);

        run_sweep(2, 1'b0, cyc);
        chk("lit_s0_err", int'(err0), 8);
        chk("lit_s0_fidx", int'(fidx0), 0);
        chk("lit_s0_mask", int'(fmask0), 12'h400);
        chk("lit_s0_pass", int'(pass0), 0);

        fault = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        chk("lit_mid_pins_20", int'({a0, b0, c0, d0, e0, f0}), 6'h14);
        chk("lit_mid_err_20", int'(err0), 14);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("lit_abort_busy", int'(busy0), 0);
        chk("lit_abort_done", int'(done0), 0);
        chk("lit_abort_err", int'(err0), 0);
        chk("lit_abort_fv", int'(fv0), 0);
        chk("lit_abort_pins", int'({a0, b0, c0, d0, e0, f0}), 0);
        chk("lit_abort_pins_al", int'({a1, b1, c1, d1, e1, f1}), 6'h3F);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/comparator_stimulus_checker.md
Name: comparator_stimulus_checker

Overview:
- Self-test driver for the 3-bit word comparator board setup. It drives the comparator's six input pins and reads back its 12 result lines.
- On `start`, it sweeps all 64 (Superior, Inferior) pairs in order and checks every result line against an internally computed expected value.
- It counts mismatches and latches the first failing vector, so the comparator can be validated on hardware without toggling switches.

Parameters:
- PACE_CYCLES, 4, cycles each vector is held before checking; legal range is 2 or more.
- ACTIVE_LOW, 0, when 1 the six drive outputs are inverted (for a comparator instance built with ACTIVE_LOW=1); `y_in` is always active-high.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level, sampled each cycle; begins a sweep when in IDLE or DONE.
- y_in  input  12  result lines from the comparator, with the same bit map as its y[11:0].
- out_a  output  1  S2 drive (MSB of Superior).
- out_b  output  1  S1 drive.
- out_c  output  1  S0 drive (LSB of Superior).
- out_d  output  1  I2 drive (MSB of Inferior).
- out_e  output  1  I1 drive.
- out_f  output  1  I0 drive (LSB of Inferior).
- busy  output  1  high in APPLY or CHECK; intended for the board LED.
- done  output  1  high while in DONE.
- pass  output  1  done AND err_count==0.
- err_count  output  7  number of mismatching vectors, 0..64; counts vectors, not bits.
- fail_valid  output  1  set on the first mismatch of a sweep.
- fail_idx  output  6  vector index of the first mismatch, {S[2:0], I[2:0]}.
- fail_mask  output  12  y_in XOR expected, captured at the first mismatch.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high):
  - state=IDLE; idx=0; pace counter=0.
  - err_count=0, fail_valid=0, fail_idx=0, fail_mask=0.
  - busy=0, done=0, pass=0.
  - Drive pins are all 0, or all 1 when ACTIVE_LOW=1.
- Reset mid-sweep aborts immediately to the reset state. No partial results are kept.
- Vector map: idx[5:3] is Superior S, idx[2:0] is Inferior I. The drive pins always reflect the current idx (inverted if ACTIVE_LOW).
- Expected result for (S, I), unsigned:
  - bits [2:0]: per-bit S<I, i.e. ~S[k]&I[k].
  - bits [5:3]: per-bit S==I.
  - bits [8:6]: per-bit S>I.
  - bit 9: S<I; bit 10: S==I; bit 11: S>I.
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE:
  - start=1 moves to APPLY with idx=0, pace counter=0, and all error/fail registers cleared.
- APPLY:
  - Holds for exactly PACE_CYCLES cycles, covering comparator and pin settling.
  - Then moves to CHECK.
- CHECK (1 cycle):
  - Compares y_in against expected(idx).
  - On mismatch: err_count increments. If fail_valid=0, it also sets fail_valid and captures fail_idx=idx and fail_mask.
  - If idx==63, moves to DONE; otherwise idx increments and the FSM returns to APPLY.
  - idx wraps to 0 only on entry to DONE.
- DONE:
  - Results hold until start=1 or rst.
  - start=1 behaves exactly as start in IDLE (restart, results cleared).
- Timing: if start is sampled at edge E0, vector k is checked in cycle E0+k(PACE_CYCLES+1)+PACE_CYCLES. done rises at E0+64(PACE_CYCLES+1), which is 320 cycles for the default.
- start is ignored in APPLY and CHECK.
- err_count saturates naturally at 64; overflow is impossible.
- rst has priority over start in the same cycle.

Test Plan:
1. Reset, ACTIVE_LOW=0 -> all drive pins 0, busy=0, done=0, pass=0, err_count=0, fail_valid=0.
2. Golden comparator model on y_in, start pulse -> busy high, vectors 0..63 in order, done exactly 320 cycles after the start edge, pass=1, err_count=0, fail_valid=0.
3. Bench forces y_in[0] stuck at 1 -> err_count=48, fail_idx=0, fail_mask=12'h001, pass=0.
4. Bench forces y_in[10] stuck at 0 -> err_count=8 (the equal pairs only), fail_idx=0, fail_mask=12'h400.
5. start re-asserted mid-sweep -> ignored, done still at 320. start asserted in DONE -> err_count/fail cleared the next cycle and idx=0. rst asserted at idx=20 -> IDLE next cycle, all outputs at reset values.
6. ACTIVE_LOW=1 -> drive pins all 1 in IDLE. At idx=6'h2B (S=5, I=3), pins a..f read 0,1,0,1,0,0. Golden model with the same inversion gives pass=1.
